// File: rtl/pipe_memory_if.sv
// Request/response bundle for pipe_memory: read and write ports plus status flags.
// The master drives requests. The slave (the memory) returns read data and status.
interface pipe_memory_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              wr_err;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_valid, busy, wr_err
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_valid, busy, wr_err
    );
endinterface

// File: rtl/pipe_memory.sv
// Single-port-per-direction memory with a registered, write-first read path.
// After reset, every word is filled with INIT_VAL before any request is accepted.
module pipe_memory #(
    parameter int                 DATA_W   = 20,
    parameter int                 ADDR_W   = 5,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic           Clock,
    input  logic           Resetn,
    pipe_memory_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_err;
    logic [DATA_W-1:0] mem [DEPTH];

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.wr_err   = wr_err;
    assign bus.busy     = (state == CLEAR);

    // Control FSM and read register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    if (bus.wr_en)
                        wr_err <= 1'b1;
                    // The pointer parks on the last word; only reset returns it to 0.
                    if (clr_ptr == LAST_ADDR)
                        state <= READY;
                    else
                        clr_ptr <= clr_ptr + 1'b1;
                end
                READY: begin
                    if (bus.rd_en) begin
                        rd_valid <= 1'b1;
                        if (bus.wr_en && (bus.wr_addr == bus.rd_addr))
                            rd_data <= bus.wr_data;
                        else
                            rd_data <= mem[bus.rd_addr];
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage array: the reset edge itself leaves contents untouched
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            if (state == CLEAR)
                mem[clr_ptr] <= INIT_VAL;
            else if (bus.wr_en)
                mem[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
